// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined CNN float multiplier.
// Sign/exponent/mantissa layout with implied leading one and no special values.
package fp_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MANT_W = 10;
    localparam int unsigned FP_W   = EXP_W + MANT_W + 1;
    localparam int unsigned PROD_W = 2 * (MANT_W + 1);

    function automatic int unsigned bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    localparam logic signed [EXP_W+1:0] BIAS_E  = (EXP_W+2)'(bias(EXP_W));
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

    // Saturated magnitude: exponent and mantissa fields all ones.
    function automatic logic [FP_W-2:0] max_mag();
        return '1;
    endfunction

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic signed [EXP_W+1:0]  exp;
        logic [MANT_W:0]          mant;
    } fp_unp_t;

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic signed [EXP_W+1:0]  exp;
        logic [MANT_W:0]          ma;
        logic [MANT_W:0]          mb;
    } s1_lane_t;

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic signed [EXP_W+1:0]  exp;
        logic [PROD_W-1:0]        prod;
    } s2_lane_t;

    typedef struct packed {
        logic [FP_W-1:0]          res;
        logic                     ovf;
        logic                     unf;
    } s3_lane_t;

    function automatic fp_unp_t unpack(input logic [FP_W-1:0] x);
        fp_unp_t u;
        u.sign = x[FP_W-1];
        u.zero = (x[FP_W-2:0] == '0);
        u.exp  = {2'b00, x[FP_W-2 -: EXP_W]};
        u.mant = {1'b1, x[MANT_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_mlt_lane.sv
// Single-lane datapath: unpack, multiply, normalise/round/range-check, each stage enable-loaded.
// FP_MLT_PIPE_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_mlt_lane
    import fp_pkg::*;
(
    input  logic            clock,
    input  logic            clock_areset_n,
    input  logic            en1_i,
    input  logic            en2_i,
    input  logic            en3_i,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] result_o,
    output logic            ovf_o,
    output logic            unf_o
);

    fp_unp_t  ua, ub;
    s1_lane_t s1_d, s1_q;
    s2_lane_t s2_d, s2_q;
    s3_lane_t s3_d, s3_q;

    logic signed [EXP_W+1:0] e_n;
    logic [MANT_W-1:0]       m_n;
    logic                    guard, sticky;

    always_comb begin
        ua        = unpack(a_i);
        ub        = unpack(b_i);
        s1_d.sign = ua.sign ^ ub.sign;
        s1_d.zero = ua.zero | ub.zero;
        s1_d.exp  = ua.exp + ub.exp - BIAS_E;
        s1_d.ma   = ua.mant;
        s1_d.mb   = ub.mant;
    end

    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.exp  = s1_q.exp;
        s2_d.prod = PROD_W'(s1_q.ma) * PROD_W'(s1_q.mb);
    end

`ifdef FP_MLT_PIPE_RNE_EN
    logic              inc;
    logic [MANT_W:0]   m_r;
`else
    logic              unused_rnd;
    assign unused_rnd = guard ^ sticky;
`endif

    always_comb begin
        // Product lies in [1,4): a set MSB means one extra bit of exponent.
        if (s2_q.prod[PROD_W-1]) begin
            e_n    = s2_q.exp + EXP_ONE;
            m_n    = s2_q.prod[PROD_W-2 -: MANT_W];
            guard  = s2_q.prod[PROD_W-2-MANT_W];
            sticky = |s2_q.prod[PROD_W-3-MANT_W:0];
        end else begin
            e_n    = s2_q.exp;
            m_n    = s2_q.prod[PROD_W-3 -: MANT_W];
            guard  = s2_q.prod[PROD_W-3-MANT_W];
            sticky = |s2_q.prod[PROD_W-4-MANT_W:0];
        end
`ifdef FP_MLT_PIPE_RNE_EN
        inc = guard & (sticky | m_n[0]);
        m_r = {1'b0, m_n} + {{MANT_W{1'b0}}, inc};
        if (m_r[MANT_W]) begin
            e_n = e_n + EXP_ONE;
        end
        m_n = m_r[MANT_W-1:0];
`endif
        s3_d = '0;
        if (s2_q.zero) begin
            s3_d = '0;
        end else if (e_n > EXP_MAX) begin
            s3_d.res = {s2_q.sign, max_mag()};
            s3_d.ovf = 1'b1;
        end else if (e_n[EXP_W+1] || (e_n[EXP_W-1:0] == '0 && m_n == '0)) begin
            s3_d.unf = 1'b1;
        end else begin
            s3_d.res = {s2_q.sign, e_n[EXP_W-1:0], m_n};
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (en1_i) s1_q <= s1_d;
            if (en2_i) s2_q <= s2_d;
            if (en3_i) s3_q <= s3_d;
        end
    end

    assign result_o = s3_q.res;
    assign ovf_o    = s3_q.ovf;
    assign unf_o    = s3_q.unf;

endmodule

// File: rtl/fp_mlt_pipe.sv
// LANES-wide three-stage float multiplier with one shared valid/ready handshake.
// Define FP_MLT_PIPE_RNE_EN for round-to-nearest-even; default build truncates.
module fp_mlt_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP   = EXP_W,
    parameter int unsigned MANT  = MANT_W,
    parameter int unsigned WIDTH = EXP + MANT + 1,
    parameter int unsigned LANES = 4
) (
    input  logic                   clock,
    input  logic                   clock_areset_n,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [LANES*WIDTH-1:0] dataa,
    input  logic [LANES*WIDTH-1:0] datab,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       result_ovf,
    output logic [LANES-1:0]       result_unf
);

    logic [2:0] valid_d, valid_q;
    logic       ld1, ld2, ld3;
    logic       en1, en2, en3;

    // A stage may load when empty or when its successor takes its content this cycle.
    always_comb begin
        ld3     = ~valid_q[2] | result_ready;
        ld2     = ~valid_q[1] | ld3;
        ld1     = ~valid_q[0] | ld2;
        en1     = ld1 & data_valid;
        en2     = ld2 & valid_q[0];
        en3     = ld3 & valid_q[1];
        valid_d = {ld3 ? valid_q[1] : valid_q[2],
                   ld2 ? valid_q[0] : valid_q[1],
                   ld1 ? data_valid : valid_q[0]};
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign data_ready   = ld1;
    assign result_valid = valid_q[2];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_mlt_lane u_lane (
            .clock          (clock),
            .clock_areset_n (clock_areset_n),
            .en1_i          (en1),
            .en2_i          (en2),
            .en3_i          (en3),
            .a_i            (dataa[i*WIDTH +: WIDTH]),
            .b_i            (datab[i*WIDTH +: WIDTH]),
            .result_o       (result[i*WIDTH +: WIDTH]),
            .ovf_o          (result_ovf[i]),
            .unf_o          (result_unf[i])
        );
    end

endmodule

// File: tb/tb_fp_mlt_pipe.sv
// Directed bench for fp_mlt_pipe: arithmetic vectors, latency, backpressure and async reset.
module tb_fp_mlt_pipe;

    localparam int W = 16;
    localparam int L = 4;

`ifdef FP_MLT_PIPE_RNE_EN
    localparam logic [15:0] TIE_EXP = 16'h3E02;
`else
    localparam logic [15:0] TIE_EXP = 16'h3E01;
`endif

    logic           clock = 1'b0;
    logic           clock_areset_n = 1'b0;
    logic           data_valid = 1'b0;
    logic           data_ready;
    logic [L*W-1:0] dataa = '0;
    logic [L*W-1:0] datab = '0;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [L*W-1:0] result;
    logic [L-1:0]   result_ovf;
    logic [L-1:0]   result_unf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fp_mlt_pipe dut (
        .clock          (clock),
        .clock_areset_n (clock_areset_n),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .dataa          (dataa),
        .datab          (datab),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result),
        .result_ovf     (result_ovf),
        .result_unf     (result_unf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered #1 after a rising edge with an empty pipe and result_ready high.
    task automatic txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_r, input logic [3:0] exp_o,
                       input logic [3:0] exp_u);
        dataa      = a;
        datab      = b;
        data_valid = 1'b1;
        #1;
        check({tag, " ready"}, data_ready, 1);
        @(posedge clock); #1;
        data_valid = 1'b0;
        check({tag, " valid+1"}, result_valid, 0);
        @(posedge clock); #1;
        check({tag, " valid+2"}, result_valid, 0);
        @(posedge clock); #1;
        check({tag, " valid+3"}, result_valid, 1);
        check({tag, " result"}, result, exp_r);
        check({tag, " ovf"}, result_ovf, exp_o);
        check({tag, " unf"}, result_unf, exp_u);
        @(posedge clock); #1;
        check({tag, " drained"}, result_valid, 0);
    endtask

    logic [63:0] q[$];
    logic [63:0] held;
    logic        held_v;
    logic [15:0] idx;
    int          sent, got_n, ready_lo;

    initial begin
        #1;
        check("rst valid", result_valid, 0);
        check("rst result", result, 64'h0);
        check("rst flags", {result_ovf, result_unf}, 8'h00);
        repeat (2) @(posedge clock);
        #3 clock_areset_n = 1'b1;
        @(posedge clock); #1;
        check("rst ready", data_ready, 1);
        result_ready = 1'b1;

        txn("basic", {16'h8000, 16'h0000, 16'hC000, 16'h3E00},
                     {16'hC400, 16'h7BFF, 16'h4200, 16'h3E00},
                     {16'h0000, 16'h0000, 16'hC600, 16'h4080}, 4'b0000, 4'b0000);
        txn("range", {16'h3C00, 16'h0400, 16'hFC00, 16'h7C00},
                     {16'h3C00, 16'h0400, 16'h7C00, 16'h7C00},
                     {16'h3C00, 16'h0000, 16'hFFFF, 16'h7FFF}, 4'b0011, 4'b0100);
        txn("round", {16'h3800, 16'h3C01, 16'h3E00, 16'h3C01},
                     {16'h0400, 16'h3C01, 16'h3C01, 16'h3E00},
                     {16'h0000, 16'h3C02, TIE_EXP, TIE_EXP}, 4'b0000, 4'b1000);
        txn("edge", {16'h0400, 16'hBC00, 16'h3C00, 16'h7800},
                    {16'h3C00, 16'hBC00, 16'h0000, 16'h4000},
                    {16'h0400, 16'h3C00, 16'h0000, 16'h7C00}, 4'b0000, 4'b0000);

        // Ten back-to-back operands; output stalled during cycles 4..8.
        sent = 0; got_n = 0; ready_lo = 0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got_n < 10; cyc++) begin
            idx          = 16'(sent);
            result_ready = !(cyc >= 4 && cyc <= 8);
            data_valid   = (sent < 10);
            dataa        = {16'h3C00, 16'h3C00, 16'hC000, 16'h3C00 + idx};
            datab        = {16'h3C00, 16'h3C00, 16'h3C00 + idx, 16'h4000};
            #1;
            if (cyc == 3) check("bp ready c3", data_ready, 1);
            if (cyc == 4) check("bp ready c4", data_ready, 0);
            if (!data_ready) ready_lo++;
            if (result_valid) begin
                check("bp nonempty", (q.size() != 0), 1);
                if (q.size() != 0) check("bp order", result, q[0]);
                if (!result_ready) begin
                    if (held_v) check("bp hold", result, held);
                    held   = result;
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                    if (q.size() != 0) void'(q.pop_front());
                    got_n++;
                end
            end
            if (data_valid && data_ready) begin
                q.push_back({16'h3C00, 16'h3C00, 16'hC000 | idx, 16'h4000 | idx});
                sent++;
            end
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        check("bp sent", sent, 10);
        check("bp received", got_n, 10);
        check("bp leftover", q.size(), 0);
        check("bp ready low cycles", ready_lo, 5);

        // Fill all three stages with output stalled, then reset mid-stream.
        result_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dataa      = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
            datab      = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
            data_valid = 1'b1;
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        check("full valid", result_valid, 1);
        check("full ready", data_ready, 0);
        check("full result", result, {16'h4000, 16'h4000, 16'h4000, 16'h4000});
        #2 clock_areset_n = 1'b0;
        #1;
        check("async valid", result_valid, 0);
        check("async result", result, 64'h0);
        @(posedge clock);
        @(posedge clock);
        #3 clock_areset_n = 1'b1;
        result_ready = 1'b1;
        @(posedge clock); #1;
        check("post rst ready", data_ready, 1);
        for (int k = 0; k < 3; k++) begin
            check("no stale", result_valid, 0);
            @(posedge clock); #1;
        end
        txn("post rst", {16'h3555, 16'h0000, 16'hC400, 16'h4200},
                        {16'h3C00, 16'h0000, 16'h3C00, 16'h4200},
                        {16'h3555, 16'h0000, 16'hC400, 16'h4880}, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
